// File: rtl/rename_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rename_pkg
//  Purpose  : Shared types and constants for the rename/dispatch controller.
//             - default geometry and derived widths
//             - register status table entry (valid + producer tag)
//             - issue queue index encoding
//  Revision : 1.0  initial release
// ============================================================================
package rename_pkg;

    localparam int c_default_num_tags  = 64;
    localparam int c_default_arch_regs = 32;
    localparam int c_default_tag_w     = $clog2(c_default_num_tags);
    localparam int c_default_areg_w    = $clog2(c_default_arch_regs);

    // Storage width of the tag field in an RST entry. Instances narrower
    // than this keep the upper bits at zero; NUM_TAGS must not exceed
    // 2**c_tag_w_max.
    localparam int c_tag_w_max = 16;

    typedef struct packed {
        logic                   valid;
        logic [c_tag_w_max-1:0] tag;
    } rst_entry_t;

    // Bit position of each issue queue inside the one-hot q_sel/q_full/q_en
    typedef enum logic [1:0] {
        Q_INT  = 2'd0,
        Q_LDST = 2'd1,
        Q_MULT = 2'd2,
        Q_DIV  = 2'd3
    } queue_idx_e;

endpackage : rename_pkg
`default_nettype wire

// File: rtl/tag_free_list.sv
`default_nettype none
// ============================================================================
//  Module   : tag_free_list
//  Purpose  : Circular FIFO of free physical rename tags. Resets full, holding
//             tags 0..NUM_TAGS-1 in order. Pushes while full are dropped and
//             raise a sticky overflow flag.
//  Ports    : clk, rst (sync, active-low)
//             push/push_tag : return a tag to the tail
//             pop           : consume the head tag
//             head_tag      : tag at the head (next allocation)
//             count         : number of free tags (0..NUM_TAGS)
//             ovf           : sticky, push attempted while full
//  Revision : 1.0  initial release
// ============================================================================
module tag_free_list #(
    parameter int NUM_TAGS = 64,
    parameter int TAG_W    = $clog2(NUM_TAGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output logic [TAG_W-1:0] head_tag,
    output logic [TAG_W:0]   count,
    output logic             ovf
);

    localparam logic [TAG_W:0] c_full = (TAG_W+1)'(NUM_TAGS);

    logic [TAG_W-1:0] r_mem [NUM_TAGS];
    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [TAG_W:0]   r_count;
    logic             r_ovf;

    logic w_full;
    logic w_push_ok;
    logic w_pop_ok;

    assign w_full    = (r_count == c_full);
    assign w_push_ok = push & ~w_full;
    assign w_pop_ok  = pop & (r_count != '0);

    // NUM_TAGS is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                r_mem[i] <= TAG_W'(i);
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= c_full;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_tail] <= push_tag;
                r_tail        <= r_tail + 1'b1;
            end
            if (w_pop_ok) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (push && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign head_tag = r_mem[r_head];
    assign count    = r_count;
    assign ovf      = r_ovf;

endmodule : tag_free_list
`default_nettype wire

// File: rtl/rename_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rename_dispatch_ctrl
//  Purpose  : Rename and dispatch control between decode and the issue
//             queues: tag free-list, register status table, CDB operand
//             forwarding, outstanding-branch stall and queue backpressure.
//  Ports    : clk, rst (sync, active-low)
//             disp_valid/disp_ready     : dispatch handshake (fire = both)
//             rs1/rs2/rd_addr, rd_wr    : operand and destination registers
//             is_branch, q_sel, q_full  : branch flag, target queue, backpressure
//             q_en                      : one-hot enqueue strobe
//             rsN_tag/pend/sel_cdb      : operand producer status
//             rd_tag                    : tag allocated to rd
//             cdb_valid/tag/branch      : completion broadcast, branch resolve
//             rf_wen/rf_waddr           : register-file write qualification
//             free_cnt, err_ovf         : free tags, sticky free-list overflow
//  Revision : 1.0  initial release
// ============================================================================
module rename_dispatch_ctrl
    import rename_pkg::*;
#(
    parameter int NUM_TAGS   = c_default_num_tags,
    parameter int ARCH_REGS  = c_default_arch_regs,
    parameter int NUM_QUEUES = 4,
    parameter int MAX_BR     = 1,
    parameter int TAG_W      = $clog2(NUM_TAGS),
    parameter int AREG_W     = $clog2(ARCH_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  disp_valid,
    output logic                  disp_ready,
    input  logic [AREG_W-1:0]     rs1_addr,
    input  logic [AREG_W-1:0]     rs2_addr,
    input  logic [AREG_W-1:0]     rd_addr,
    input  logic                  rd_wr,
    input  logic                  is_branch,
    input  logic [NUM_QUEUES-1:0] q_sel,
    input  logic [NUM_QUEUES-1:0] q_full,
    output logic [NUM_QUEUES-1:0] q_en,
    output logic [TAG_W-1:0]      rs1_tag,
    output logic [TAG_W-1:0]      rs2_tag,
    output logic                  rs1_pend,
    output logic                  rs2_pend,
    output logic                  rs1_sel_cdb,
    output logic                  rs2_sel_cdb,
    output logic [TAG_W-1:0]      rd_tag,
    input  logic                  cdb_valid,
    input  logic [TAG_W-1:0]      cdb_tag,
    input  logic                  cdb_branch,
    output logic                  rf_wen,
    output logic [AREG_W-1:0]     rf_waddr,
    output logic [TAG_W:0]        free_cnt,
    output logic                  err_ovf
);

    localparam int                c_br_w   = $clog2(MAX_BR + 1);
    localparam logic [c_br_w-1:0] c_br_max = c_br_w'(MAX_BR);

    rst_entry_t        r_rst [ARCH_REGS];
    logic [c_br_w-1:0] r_br_cnt;

    logic              w_rd_nz;
    logic              w_fire;
    logic              w_ren;
    logic              w_br_fire;
    logic              w_cdb_hit;
    logic [AREG_W-1:0] w_cdb_idx;

    // Returns {pend, sel_cdb} for one source operand.
    function automatic logic [1:0] src_status(
        input rst_entry_t       e,
        input logic             nz,
        input logic             cv,
        input logic [TAG_W-1:0] ct
    );
        if (!nz || !e.valid) begin
            return 2'b00;
        end
        if (cv && (e.tag[TAG_W-1:0] == ct)) begin
            return 2'b01;
        end
        return 2'b10;
    endfunction

    // ---------------------------------------------------------------- handshake
    assign w_rd_nz    = (rd_addr != '0);
    assign disp_ready = ~|(q_sel & q_full)
                      & ~(rd_wr & w_rd_nz & (free_cnt == '0))
                      & ~(is_branch & (r_br_cnt == c_br_max));
    assign w_fire     = disp_valid & disp_ready;
    assign w_ren      = w_fire & rd_wr & w_rd_nz;
    assign w_br_fire  = w_fire & is_branch;
    assign q_en       = q_sel & {NUM_QUEUES{w_fire}};

    // ------------------------------------------------------------ source lookup
    // Reads the table before this cycle's update, so rs==rd sees the old map.
    assign {rs1_pend, rs1_sel_cdb} = src_status(r_rst[rs1_addr], (rs1_addr != '0), cdb_valid, cdb_tag);
    assign {rs2_pend, rs2_sel_cdb} = src_status(r_rst[rs2_addr], (rs2_addr != '0), cdb_valid, cdb_tag);
    assign rs1_tag = r_rst[rs1_addr].tag[TAG_W-1:0];
    assign rs2_tag = r_rst[rs2_addr].tag[TAG_W-1:0];

    // ---------------------------------------------------------------- CDB match
    // A live tag is mapped by at most one register, so the match is unique.
    always_comb begin
        w_cdb_hit = 1'b0;
        w_cdb_idx = '0;
        for (int i = 1; i < ARCH_REGS; i++) begin
            if (r_rst[i].valid && (r_rst[i].tag[TAG_W-1:0] == cdb_tag)) begin
                w_cdb_hit = 1'b1;
                w_cdb_idx = AREG_W'(i);
            end
        end
    end

    // An entry renamed in the same cycle now belongs to a younger producer,
    // so the completing result must not be written back for it.
    assign rf_wen   = cdb_valid & w_cdb_hit & ~(w_ren & (rd_addr == w_cdb_idx));
    assign rf_waddr = w_cdb_idx;

    // --------------------------------------------------------- status table
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                r_rst[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                if (w_ren && (rd_addr == AREG_W'(i))) begin
                    r_rst[i] <= '{valid: 1'b1, tag: c_tag_w_max'(rd_tag)};
                end else if (rf_wen && (w_cdb_idx == AREG_W'(i))) begin
                    r_rst[i].valid <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------- branch counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_br_cnt <= '0;
        end else if (w_br_fire && cdb_branch) begin
            r_br_cnt <= r_br_cnt;
        end else if (w_br_fire) begin
            r_br_cnt <= r_br_cnt + 1'b1;
        end else if (cdb_branch && (r_br_cnt != '0)) begin
            r_br_cnt <= r_br_cnt - 1'b1;
        end
    end

    // ------------------------------------------------------------ free-list
    tag_free_list #(
        .NUM_TAGS (NUM_TAGS),
        .TAG_W    (TAG_W)
    ) u_free_list (
        .clk      (clk),
        .rst      (rst),
        .push     (cdb_valid),
        .push_tag (cdb_tag),
        .pop      (w_ren),
        .head_tag (rd_tag),
        .count    (free_cnt),
        .ovf      (err_ovf)
    );

endmodule : rename_dispatch_ctrl
`default_nettype wire

// File: tb/tb_rename_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rename_dispatch_ctrl
//  Purpose  : Self-checking bench for rename_dispatch_ctrl. A queue/array
//             model of the free-list, register map and branch count predicts
//             every output each cycle; literal checks pin key scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rename_dispatch_ctrl;
    import rename_pkg::*;

    localparam int NT = 64;
    localparam int AR = 32;
    localparam int NQ = 4;
    localparam int MB = 2;
    localparam int TW = 6;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          disp_valid, disp_ready;
    logic [AW-1:0] rs1_addr, rs2_addr, rd_addr;
    logic          rd_wr, is_branch;
    logic [NQ-1:0] q_sel, q_full, q_en;
    logic [TW-1:0] rs1_tag, rs2_tag, rd_tag;
    logic          rs1_pend, rs2_pend, rs1_sel_cdb, rs2_sel_cdb;
    logic          cdb_valid, cdb_branch;
    logic [TW-1:0] cdb_tag;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [TW:0]   free_cnt;
    logic          err_ovf;

    always #5 clk = ~clk;

    rename_dispatch_ctrl #(
        .NUM_TAGS(NT), .ARCH_REGS(AR), .NUM_QUEUES(NQ), .MAX_BR(MB)
    ) dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rd_wr(rd_wr), .is_branch(is_branch),
        .q_sel(q_sel), .q_full(q_full), .q_en(q_en),
        .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
        .rs1_pend(rs1_pend), .rs2_pend(rs2_pend),
        .rs1_sel_cdb(rs1_sel_cdb), .rs2_sel_cdb(rs2_sel_cdb),
        .rd_tag(rd_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_branch(cdb_branch),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr),
        .free_cnt(free_cnt), .err_ovf(err_ovf)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model
    bit m_valid [AR];
    int m_tag   [AR];
    int fq[$];
    int inflight[$];
    int m_br;
    bit m_ovf;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic src_chk(input string n, input logic [AW-1:0] a, input logic p,
                           input logic s, input logic [TW-1:0] t);
        bit ep, es;
        ep = 1'b0;
        es = 1'b0;
        if (a != 0 && m_valid[a]) begin
            if (cdb_valid && m_tag[a] == int'(cdb_tag)) es = 1'b1;
            else                                         ep = 1'b1;
        end
        chk({n, "_pend"}, 32'(p), 32'(ep));
        chk({n, "_sel_cdb"}, 32'(s), 32'(es));
        if (ep) chk({n, "_tag"}, 32'(t), m_tag[a]);
    endtask

    // Compare current outputs against the model, then advance the model
    // across the coming clock edge.
    task automatic model_step();
        bit ready, fire, ren, e_wen, full;
        int hit, t;
        ready = !(|(q_sel & q_full)) && !(rd_wr && rd_addr != 0 && fq.size() == 0)
                && !(is_branch && m_br == MB);
        fire  = disp_valid && ready;
        ren   = fire && rd_wr && rd_addr != 0;
        hit   = -1;
        for (int r = 1; r < AR; r++)
            if (m_valid[r] && m_tag[r] == int'(cdb_tag)) hit = r;
        e_wen = cdb_valid && hit >= 0 && !(ren && int'(rd_addr) == hit);
        full  = (fq.size() == NT);

        if (chk_en) begin
            chk("disp_ready", 32'(disp_ready), 32'(ready));
            chk("q_en", 32'(q_en), fire ? 32'(q_sel) : 32'd0);
            chk("free_cnt", 32'(free_cnt), fq.size());
            chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
            chk("rf_wen", 32'(rf_wen), 32'(e_wen));
            if (e_wen) chk("rf_waddr", 32'(rf_waddr), hit);
            if (fq.size() > 0) chk("rd_tag", 32'(rd_tag), fq[0]);
            src_chk("rs1", rs1_addr, rs1_pend, rs1_sel_cdb, rs1_tag);
            src_chk("rs2", rs2_addr, rs2_pend, rs2_sel_cdb, rs2_tag);
        end

        if (!rst) begin
            fq.delete();
            for (int i = 0; i < NT; i++) fq.push_back(i);
            for (int i = 0; i < AR; i++) m_valid[i] = 1'b0;
            inflight.delete();
            m_br  = 0;
            m_ovf = 1'b0;
        end else begin
            if (fire && is_branch && cdb_branch) m_br = m_br;
            else if (fire && is_branch)          m_br++;
            else if (cdb_branch && m_br > 0)     m_br--;
            if (ren) begin
                t = fq.pop_front();
                m_valid[rd_addr] = 1'b1;
                m_tag[rd_addr]   = t;
                inflight.push_back(t);
            end
            if (cdb_valid) begin
                if (e_wen) m_valid[hit] = 1'b0;
                if (full) m_ovf = 1'b1;
                else      fq.push_back(int'(cdb_tag));
                for (int i = 0; i < inflight.size(); i++)
                    if (inflight[i] == int'(cdb_tag)) begin
                        inflight.delete(i);
                        break;
                    end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0; rd_addr = '0; rd_wr = 1'b0; is_branch = 1'b0;
        rs1_addr = '0; rs2_addr = '0; q_sel = '0; q_full = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_branch = 1'b0;
    endtask

    task automatic disp(input int rd, input bit wr, input bit br, input logic [NQ-1:0] qs);
        idle();
        disp_valid = 1'b1; rd_addr = AW'(rd); rd_wr = wr; is_branch = br; q_sel = qs;
    endtask

    int saved_tag;
    int k;

    initial begin
        rst = 1'b0;
        idle();
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b1;

        // Reset state
        idle(); #1;
        chk("lit_reset_free_cnt", 32'(free_cnt), 64);
        chk("lit_reset_ready", 32'(disp_ready), 1);
        chk("lit_reset_rf_wen", 32'(rf_wen), 0);
        step();

        // Three renames
        disp(5, 1, 0, 4'b0001); #1; chk("lit_rd_tag_x5", 32'(rd_tag), 0); step();
        disp(6, 1, 0, 4'b0001); #1; chk("lit_rd_tag_x6", 32'(rd_tag), 1); step();
        disp(7, 1, 0, 4'b0001); #1; chk("lit_rd_tag_x7", 32'(rd_tag), 2); step();
        idle(); rs1_addr = 6; #1;
        chk("lit_x6_pend", 32'(rs1_pend), 1);
        chk("lit_x6_tag", 32'(rs1_tag), 1);
        chk("lit_free_61", 32'(free_cnt), 61);
        step();

        // CDB forwarding and write-back of x5
        idle(); rs1_addr = 5; cdb_valid = 1'b1; cdb_tag = 0; #1;
        chk("lit_x5_sel_cdb", 32'(rs1_sel_cdb), 1);
        chk("lit_x5_pend_fwd", 32'(rs1_pend), 0);
        chk("lit_rf_wen_x5", 32'(rf_wen), 1);
        chk("lit_rf_waddr_x5", 32'(rf_waddr), 5);
        step();
        idle(); rs1_addr = 5; #1;
        chk("lit_x5_cleared", 32'(rs1_pend), 0);
        chk("lit_free_62", 32'(free_cnt), 62);
        step();

        // Branch counter with MAX_BR=2
        disp(0, 0, 1, 4'b0001); #1; chk("lit_br1_ready", 32'(disp_ready), 1); step();
        disp(0, 0, 1, 4'b0001); #1; chk("lit_br2_ready", 32'(disp_ready), 1); step();
        disp(0, 0, 1, 4'b0001); #1; chk("lit_br3_stall", 32'(disp_ready), 0); step();
        disp(0, 0, 1, 4'b0001); cdb_branch = 1'b1; #1;
        chk("lit_br3_stall_resolve", 32'(disp_ready), 0); step();
        disp(0, 0, 1, 4'b0001); #1; chk("lit_br3_accept", 32'(disp_ready), 1); step();
        idle(); cdb_branch = 1'b1; step();
        disp(0, 0, 1, 4'b0001); cdb_branch = 1'b1; #1;
        chk("lit_br_simul_ready", 32'(disp_ready), 1); step();
        disp(0, 0, 1, 4'b0001); #1; chk("lit_br_after_hold", 32'(disp_ready), 1); step();
        disp(0, 0, 1, 4'b0001); #1; chk("lit_br_full_again", 32'(disp_ready), 0); step();
        repeat (3) begin idle(); cdb_branch = 1'b1; step(); end
        disp(0, 0, 1, 4'b0001); #1; chk("lit_br_from_zero", 32'(disp_ready), 1); step();
        idle(); cdb_branch = 1'b1; step();

        // Rename x9 while its old tag completes
        disp(9, 1, 0, 4'b0001); #1; chk("lit_x9_tag3", 32'(rd_tag), 3); step();
        disp(9, 1, 0, 4'b0001); cdb_valid = 1'b1; cdb_tag = 3; #1;
        chk("lit_x9_tag4", 32'(rd_tag), 4);
        chk("lit_x9_no_wb", 32'(rf_wen), 0);
        step();
        idle(); rs1_addr = 9; rs2_addr = 9; #1;
        chk("lit_x9_pend", 32'(rs1_pend), 1);
        chk("lit_x9_newtag", 32'(rs1_tag), 4);
        step();
        disp(0, 1, 0, 4'b0001); #1; chk("lit_x0_ready", 32'(disp_ready), 1); step();
        idle(); #1; chk("lit_x0_no_pop", 32'(free_cnt), 61); step();

        // Queue backpressure
        disp(0, 0, 0, 4'b0010); q_full = 4'b0010; #1;
        chk("lit_qfull_stall", 32'(disp_ready), 0);
        chk("lit_qfull_qen", 32'(q_en), 0);
        step();
        disp(0, 0, 0, 4'b0010); q_full = 4'b0001; #1;
        chk("lit_qother_ready", 32'(disp_ready), 1);
        chk("lit_qen_ldst", 32'(q_en), 4'b0010);
        step();

        // Exhaust the free-list
        k = 0;
        while (fq.size() > 0 && k < NT + 4) begin
            disp(1 + (k % 31), 1, 0, 4'b0100);
            step();
            k++;
        end
        disp(12, 1, 0, 4'b0001); #1; chk("lit_empty_stall", 32'(disp_ready), 0); step();
        saved_tag = m_tag[12];
        disp(12, 1, 0, 4'b0001); cdb_valid = 1'b1; cdb_tag = TW'(saved_tag); #1;
        chk("lit_empty_stall_cdb", 32'(disp_ready), 0);
        chk("lit_empty_cdb_wb", 32'(rf_wen), 1);
        step();
        disp(12, 1, 0, 4'b0001); #1;
        chk("lit_refill_ready", 32'(disp_ready), 1);
        chk("lit_refill_tag", 32'(rd_tag), saved_tag);
        chk("lit_refill_cnt", 32'(free_cnt), 1);
        step();
        idle(); #1; chk("lit_empty_again", 32'(free_cnt), 0); step();

        // Reset mid-stream
        disp(13, 1, 0, 4'b0001); rst = 1'b0; step();
        rst = 1'b1; idle(); rs1_addr = 12; rs2_addr = 9; #1;
        chk("lit_mid_rst_free", 32'(free_cnt), 64);
        chk("lit_mid_rst_rs1", 32'(rs1_pend), 0);
        chk("lit_mid_rst_rs2", 32'(rs2_pend), 0);
        step();

        // Overflow: push while full
        idle(); cdb_valid = 1'b1; cdb_tag = 7; #1; chk("lit_ovf_before", 32'(err_ovf), 0); step();
        idle(); #1;
        chk("lit_ovf_set", 32'(err_ovf), 1);
        chk("lit_ovf_free", 32'(free_cnt), 64);
        step();

        // Mixed traffic driven against the model
        for (int n = 0; n < 300; n++) begin
            idle();
            disp_valid = ($urandom_range(0, 3) != 0);
            rd_addr    = AW'($urandom_range(0, 7));
            rd_wr      = $urandom_range(0, 1);
            is_branch  = ($urandom_range(0, 7) == 0);
            q_sel      = NQ'(1 << $urandom_range(0, NQ - 1));
            q_full     = ($urandom_range(0, 3) == 0) ? NQ'($urandom_range(0, 15)) : '0;
            rs1_addr   = AW'($urandom_range(0, 7));
            rs2_addr   = AW'($urandom_range(0, 7));
            cdb_branch = ($urandom_range(0, 5) == 0);
            if (inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
                cdb_valid = 1'b1;
                cdb_tag   = TW'(inflight[$urandom_range(0, inflight.size() - 1)]);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rename_dispatch_ctrl
`default_nettype wire
